// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: framed byte stream in, 32-bit im writes out.
// Keeps the CPU in reset until a length-checked, checksum-verified image is in place.
module im_loader #(
  parameter int ADDR_W    = 16,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] LP_MAX = 17'(MAX_WORDS);

  state_t r_state;
  state_t w_next;

  logic [15:0]       r_len;
  logic [1:0]        r_idx;
  logic [31:0]       r_word;
  logic [7:0]        r_csum;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_words;

  logic        w_xfer;
  logic        w_go;
  logic        w_last;
  logic        w_ready;
  logic [15:0] w_len;

  assign w_len  = {r_len[15:8], rx_data};
  assign w_xfer = rx_valid & w_ready;
  assign w_last = ((r_words + 16'd1) == r_len);
  assign w_go   = start & ((r_state == S_IDLE) |
                           (r_state == S_DONE) |
                           (r_state == S_ERR));

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_go) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        w_ready = 1'b1;
        if (w_xfer) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        w_ready = 1'b1;
        if (w_xfer) begin
          if (w_len == 16'd0)              w_next = S_CSUM;
          else if ({1'b0, w_len} > LP_MAX) w_next = S_ERR;
          else                             w_next = S_DATA;
        end
      end
      S_DATA: begin
        w_ready = 1'b1;
        if (w_xfer && (r_idx == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = w_last ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        w_ready = 1'b1;
        if (w_xfer) w_next = (rx_data == r_csum) ? S_DONE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Address stops at the last written word so it never leaves the image.
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      r_len   <= '0;
      r_idx   <= '0;
      r_word  <= '0;
      r_csum  <= '0;
      r_addr  <= '0;
      r_words <= '0;
    end else if (w_go) begin
      r_len   <= '0;
      r_idx   <= '0;
      r_csum  <= '0;
      r_addr  <= '0;
      r_words <= '0;
    end else begin
      unique case (r_state)
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len[15:8] <= rx_data;
            r_csum      <= r_csum ^ rx_data;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len  <= w_len;
            r_csum <= r_csum ^ rx_data;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_word <= {r_word[23:0], rx_data};
            r_idx  <= r_idx + 2'd1;
            r_csum <= r_csum ^ rx_data;
          end
        end
        S_WRITE: begin
          r_words <= r_words + 16'd1;
          if (!w_last) r_addr <= r_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rx_ready     = w_ready;
  assign im_we        = (r_state == S_WRITE);
  assign im_addr      = r_addr;
  assign im_wdata     = r_word;
  assign cpu_hold     = (r_state != S_DONE);
  assign done         = (r_state == S_DONE);
  assign err          = (r_state == S_ERR);
  assign busy         = ~((r_state == S_IDLE) |
                          (r_state == S_DONE) |
                          (r_state == S_ERR));
  assign words_loaded = r_words;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: frames built from a byte-list model,
// expected im writes queued up front and popped by a negedge monitor.
module tb_im_loader;
  localparam int MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [15:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  im_loader #(.ADDR_W(16), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_f(rst_f), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  frame[$];
  logic [47:0] exp_q[$];
  int   wait6;
  logic e_done, e_err;
  logic [15:0] e_words;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_f && im_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got %0h@%0h want none",
                 im_wdata, im_addr);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {16'h0, im_addr}, {16'h0, e[47:32]});
        chk("wr_data", im_wdata, e[31:0]);
      end
    end
  end

  // Reference: derive writes and final status straight from the frame bytes.
  task automatic model();
    int n;
    logic [7:0] x;
    n = {frame[0], frame[1]};
    e_done = 1'b0;
    e_err  = 1'b0;
    e_words = 16'd0;
    if (n > MAXW) begin
      e_err = 1'b1;
      return;
    end
    x = frame[0] ^ frame[1];
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = {frame[2+4*i], frame[3+4*i], frame[4+4*i], frame[5+4*i]};
      x = x ^ frame[2+4*i] ^ frame[3+4*i] ^ frame[4+4*i] ^ frame[5+4*i];
      exp_q.push_back({16'(i), w});
    end
    e_words = 16'(n);
    if (frame[2+4*n] == x) e_done = 1'b1;
    else                   e_err  = 1'b1;
  endtask

  task automatic make_frame(input int n, input bit bad);
    logic [7:0] x;
    logic [15:0] nn;
    nn = 16'(n);
    frame.delete();
    frame.push_back(nn[15:8]);
    frame.push_back(nn[7:0]);
    x = nn[15:8] ^ nn[7:0];
    for (int i = 0; i < 4 * n; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      frame.push_back(b);
      x = x ^ b;
    end
    frame.push_back(bad ? (x ^ 8'h5a) : x);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap,
                           output int waited);
    int t;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    waited = t;
    if (!rx_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_timeout: got rx_ready=0 want 1");
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic run_frame(input int gmax, input bit mid_start);
    int nsend;
    int w;
    int t;
    nsend = frame.size();
    if ({frame[0], frame[1]} > MAXW) nsend = 2;
    model();
    pulse_start();
    for (int i = 0; i < nsend; i++) begin
      send_byte(frame[i], $urandom_range(0, gmax), w);
      if (i == 6) wait6 = w;
      if (mid_start && i == 3) pulse_start();
    end
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("end_busy", {31'h0, busy}, 32'h0);
    chk("end_done", {31'h0, done}, {31'h0, e_done});
    chk("end_err", {31'h0, err}, {31'h0, e_err});
    chk("end_hold", {31'h0, cpu_hold}, {31'h0, ~e_done});
    chk("end_words", {16'h0, words_loaded}, {16'h0, e_words});
    chk("end_ready", {31'h0, rx_ready}, 32'h0);
    chk("pending_wr", exp_q.size(), 32'h0);
  endtask

  task automatic nominal_frame(input logic [7:0] cs);
    frame.delete();
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
              8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
    frame[10] = cs;
  endtask

  initial begin
    int w;
    rst_f = 1'b1;
    start = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, rx_ready}, 32'h0);
    chk("rst_we", {31'h0, im_we}, 32'h0);
    chk("rst_addr", {16'h0, im_addr}, 32'h0);
    chk("rst_wdata", im_wdata, 32'h0);
    chk("rst_hold", {31'h0, cpu_hold}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_words", {16'h0, words_loaded}, 32'h0);
    rst_f = 1'b0;
    @(negedge clk);

    // nominal, back-to-back bytes: 2nd word's first byte waits out WRITE
    nominal_frame(8'h02);
    wait6 = -1;
    run_frame(0, 1'b0);
    chk("write_stall", wait6, 32'd1);

    nominal_frame(8'h03);
    run_frame(0, 1'b0);

    frame = '{8'h00, 8'h00, 8'h00};
    run_frame(0, 1'b0);

    frame = '{8'h04, 8'h01};
    run_frame(0, 1'b0);

    // reset after the first word has been written
    nominal_frame(8'h02);
    exp_q.push_back({16'h0, 32'h12345678});
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(frame[i], 0, w);
    @(negedge clk);
    rst_f = 1'b1;
    #1;
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_hold", {31'h0, cpu_hold}, 32'h1);
    chk("mid_rst_we", {31'h0, im_we}, 32'h0);
    chk("mid_rst_words", {16'h0, words_loaded}, 32'h0);
    chk("mid_rst_ready", {31'h0, rx_ready}, 32'h0);
    @(negedge clk);
    rst_f = 1'b0;
    @(negedge clk);
    chk("mid_rst_pend", exp_q.size(), 32'h0);
    nominal_frame(8'h02);
    run_frame(0, 1'b0);

    // stalls and an ignored start inside DATA
    make_frame(1, 1'b0);
    run_frame(3, 1'b0);
    nominal_frame(8'h02);
    run_frame(2, 1'b1);

    for (int k = 0; k < 12; k++) begin
      make_frame($urandom_range(0, 5), 1'($urandom_range(0, 1)));
      run_frame(2, 1'($urandom_range(0, 1)));
    end

    make_frame(MAXW, 1'b0);
    run_frame(0, 1'b0);
    make_frame(MAXW + 1 + $urandom_range(0, 200), 1'b0);
    run_frame(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
